lcdi_index_decode: RTL and testbench



---
 rtl/lcdi_index_decode_pkg.sv | 44 ++++
 rtl/lcdi_index_decode_class_rep.sv | 40 ++++
 rtl/lcdi_index_decode.sv | 233 +++++++++++++++++++++++
 tb/tb_lcdi_index_decode.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcdi_index_decode_pkg.sv
// ---------------------------------------------------------------------------
// lcdi_index_decode_pkg
// Shared definitions for the LCDI index decoder: FSM state encoding, class
// count, legal index range and the class-to-representative-difference table.
// No ports (package).
// ---------------------------------------------------------------------------
package lcdi_index_decode_pkg;

    localparam int LDEC_DATA_WIDTH = 8;
    localparam int LDEC_IDX_WIDTH  = 7;
    localparam int LDEC_CLS_WIDTH  = 4;
    localparam int LDEC_NCLASS     = 9;
    localparam int LDEC_IDX_MAX    = LDEC_NCLASS * LDEC_NCLASS - 1;

    typedef enum logic [2:0] {
        LDEC_IDLE = 3'd0,
        LDEC_LOAD = 3'd1,
        LDEC_DIV  = 3'd2,
        LDEC_MAP  = 3'd3,
        LDEC_OUT  = 3'd4,
        LDEC_DONE = 3'd5
    } ldec_state_e;

    // Representative signed difference for each class. Classes are symmetric
    // around class 4, which stands for "no difference". Codes 9..15 cannot be
    // produced by the divider and fall back to the neutral value.
    function automatic logic signed [7:0] ldec_rep(input logic [LDEC_CLS_WIDTH-1:0] cls);
        logic signed [7:0] rep;
        case (cls)
            4'd0:    rep = 8'sd56;
            4'd1:    rep = 8'sd40;
            4'd2:    rep = 8'sd24;
            4'd3:    rep = 8'sd10;
            4'd4:    rep = 8'sd0;
            4'd5:    rep = -8'sd10;
            4'd6:    rep = -8'sd24;
            4'd7:    rep = -8'sd40;
            4'd8:    rep = -8'sd56;
            default: rep = 8'sd0;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/lcdi_index_decode_class_rep.sv
// ---------------------------------------------------------------------------
// lcdi_class_rep
// Maps one decoded class to its representative signed difference, adds it to
// the centre pixel and saturates the result to the pixel range.
// Ports:
//   cls_i    - decoded class (0..8)
//   center_i - centre pixel
//   recon_o  - clamp(center_i + rep(cls_i)) in [0, 2^DATA_WIDTH-1]
// ---------------------------------------------------------------------------
module lcdi_class_rep
    import lcdi_index_decode_pkg::*;
#(
    parameter int DATA_WIDTH = LDEC_DATA_WIDTH
) (
    input  logic [LDEC_CLS_WIDTH-1:0] cls_i,
    input  logic [DATA_WIDTH-1:0]     center_i,
    output logic [DATA_WIDTH-1:0]     recon_o
);

    localparam int SW = DATA_WIDTH + 2;

    logic signed [7:0]    rep;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] pixMax;

    // Two extra bits of headroom let the sum go negative or past full scale
    // without wrapping, so the clamp below sees the true value.
    always_comb begin
        rep     = ldec_rep(cls_i);
        pixMax  = $signed({2'b00, {DATA_WIDTH{1'b1}}});
        sum     = $signed({2'b00, center_i}) + $signed({{(SW-8){rep[7]}}, rep});
        recon_o = sum[DATA_WIDTH-1:0];
        if (sum < $signed({SW{1'b0}})) begin
            recon_o = '0;
        end else if (sum > pixMax) begin
            recon_o = {DATA_WIDTH{1'b1}};
        end
    end

endmodule

// File: rtl/lcdi_index_decode.sv
// ---------------------------------------------------------------------------
// lcdi_index_decode
// Decodes four LCDI indices (index = G0 + 9*G1) back into their class pairs,
// maps each class to a signed difference and rebuilds the two neighbour pixel
// estimates around a shared centre pixel. One result per slot is presented on
// a valid/ready handshake.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   start                 - one-cycle request, samples index0..3/center_in
//   index0..index3        - LCDI indices for slots 0..3
//   center_in             - centre pixel shared by all slots
//   busy                  - frame in progress
//   out_valid / out_ready - result handshake
//   out_slot              - slot of the presented result
//   recon0_out/recon2_out - clamped neighbour estimates from G0 / G1
//   g0_out, g1_out        - decoded classes
//   out_err               - index above the legal range for this slot
//   done                  - one-cycle pulse after slot 3 is accepted
// ---------------------------------------------------------------------------
module lcdi_index_decode
    import lcdi_index_decode_pkg::*;
#(
    parameter int DATA_WIDTH = LDEC_DATA_WIDTH,
    parameter int IDX_MAX    = LDEC_IDX_MAX
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [LDEC_IDX_WIDTH-1:0] index0,
    input  logic [LDEC_IDX_WIDTH-1:0] index1,
    input  logic [LDEC_IDX_WIDTH-1:0] index2,
    input  logic [LDEC_IDX_WIDTH-1:0] index3,
    input  logic [DATA_WIDTH-1:0]     center_in,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                out_slot,
    output logic [DATA_WIDTH-1:0]     recon0_out,
    output logic [DATA_WIDTH-1:0]     recon2_out,
    output logic [LDEC_CLS_WIDTH-1:0] g0_out,
    output logic [LDEC_CLS_WIDTH-1:0] g1_out,
    output logic                      out_err,
    output logic                      done
);

    localparam logic [LDEC_IDX_WIDTH-1:0] IDX_LIMIT = LDEC_IDX_WIDTH'(IDX_MAX);
    localparam logic [LDEC_IDX_WIDTH-1:0] NCLASS_W  = LDEC_IDX_WIDTH'(LDEC_NCLASS);
    localparam logic [LDEC_CLS_WIDTH-1:0] CLS_NEUTRAL = 4'd4;

    ldec_state_e state_q, state_d;

    logic [LDEC_IDX_WIDTH-1:0] idx_q [4];
    logic [LDEC_IDX_WIDTH-1:0] idx_d [4];
    logic [DATA_WIDTH-1:0]     center_q, center_d;
    logic [1:0]                slot_q, slot_d;
    logic [LDEC_IDX_WIDTH-1:0] rem_q, rem_d;
    logic [LDEC_CLS_WIDTH-1:0] quo_q, quo_d;
    logic [LDEC_CLS_WIDTH-1:0] g0_q, g0_d;
    logic [LDEC_CLS_WIDTH-1:0] g1_q, g1_d;
    logic                      err_q, err_d;

    logic                      busy_q, busy_d;
    logic                      valid_q, valid_d;
    logic                      done_q, done_d;
    logic [1:0]                outSlot_q, outSlot_d;
    logic [DATA_WIDTH-1:0]     recon0_q, recon0_d;
    logic [DATA_WIDTH-1:0]     recon2_q, recon2_d;
    logic [LDEC_CLS_WIDTH-1:0] g0Out_q, g0Out_d;
    logic [LDEC_CLS_WIDTH-1:0] g1Out_q, g1Out_d;
    logic                      outErr_q, outErr_d;

    logic [DATA_WIDTH-1:0]     recon0_w;
    logic [DATA_WIDTH-1:0]     recon2_w;

    // One mapper per neighbour: G0 drives the left estimate, G1 the right.
    lcdi_class_rep #(.DATA_WIDTH(DATA_WIDTH)) u_rep_g0 (
        .cls_i    (g0_q),
        .center_i (center_q),
        .recon_o  (recon0_w)
    );

    lcdi_class_rep #(.DATA_WIDTH(DATA_WIDTH)) u_rep_g1 (
        .cls_i    (g1_q),
        .center_i (center_q),
        .recon_o  (recon2_w)
    );

    // Next-state logic. The index is split into G0 (remainder) and G1
    // (quotient) by repeated subtraction of 9, one step per cycle. Handshake
    // flags are derived from the next state so they come straight out of
    // flops and never depend combinationally on out_ready.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        center_d  = center_q;
        slot_d    = slot_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        g0_d      = g0_q;
        g1_d      = g1_q;
        err_d     = err_q;
        outSlot_d = outSlot_q;
        recon0_d  = recon0_q;
        recon2_d  = recon2_q;
        g0Out_d   = g0Out_q;
        g1Out_d   = g1Out_q;
        outErr_d  = outErr_q;

        case (state_q)
            LDEC_IDLE: begin
                if (start) begin
                    idx_d[0] = index0;
                    idx_d[1] = index1;
                    idx_d[2] = index2;
                    idx_d[3] = index3;
                    center_d = center_in;
                    slot_d   = 2'd0;
                    outErr_d = 1'b0;
                    state_d  = LDEC_LOAD;
                end
            end
            LDEC_LOAD: begin
                rem_d    = idx_q[slot_q];
                quo_d    = '0;
                outErr_d = 1'b0;
                if (idx_q[slot_q] > IDX_LIMIT) begin
                    g0_d    = CLS_NEUTRAL;
                    g1_d    = CLS_NEUTRAL;
                    err_d   = 1'b1;
                    state_d = LDEC_MAP;
                end else begin
                    err_d   = 1'b0;
                    state_d = LDEC_DIV;
                end
            end
            LDEC_DIV: begin
                if (rem_q >= NCLASS_W) begin
                    rem_d = rem_q - NCLASS_W;
                    quo_d = quo_q + 4'd1;
                end else begin
                    g0_d    = rem_q[LDEC_CLS_WIDTH-1:0];
                    g1_d    = quo_q;
                    state_d = LDEC_MAP;
                end
            end
            LDEC_MAP: begin
                outSlot_d = slot_q;
                recon0_d  = recon0_w;
                recon2_d  = recon2_w;
                g0Out_d   = g0_q;
                g1Out_d   = g1_q;
                outErr_d  = err_q;
                state_d   = LDEC_OUT;
            end
            LDEC_OUT: begin
                if (out_ready) begin
                    if (slot_q == 2'd3) begin
                        state_d = LDEC_DONE;
                    end else begin
                        slot_d   = slot_q + 2'd1;
                        outErr_d = 1'b0;
                        state_d  = LDEC_LOAD;
                    end
                end
            end
            LDEC_DONE: begin
                state_d = LDEC_IDLE;
            end
            default: begin
                state_d = LDEC_IDLE;
            end
        endcase

        valid_d = (state_d == LDEC_OUT);
        done_d  = (state_d == LDEC_DONE);
        busy_d  = (state_d != LDEC_IDLE) && (state_d != LDEC_DONE);
    end

    // State and output registers. Reset clears everything, which also aborts
    // a frame in flight without producing a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= LDEC_IDLE;
            idx_q     <= '{default: '0};
            center_q  <= '0;
            slot_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            g0_q      <= '0;
            g1_q      <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            outSlot_q <= '0;
            recon0_q  <= '0;
            recon2_q  <= '0;
            g0Out_q   <= '0;
            g1Out_q   <= '0;
            outErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            center_q  <= center_d;
            slot_q    <= slot_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            g0_q      <= g0_d;
            g1_q      <= g1_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            outSlot_q <= outSlot_d;
            recon0_q  <= recon0_d;
            recon2_q  <= recon2_d;
            g0Out_q   <= g0Out_d;
            g1Out_q   <= g1Out_d;
            outErr_q  <= outErr_d;
        end
    end

    assign busy       = busy_q;
    assign out_valid  = valid_q;
    assign done       = done_q;
    assign out_slot   = outSlot_q;
    assign recon0_out = recon0_q;
    assign recon2_out = recon2_q;
    assign g0_out     = g0Out_q;
    assign g1_out     = g1Out_q;
    assign out_err    = outErr_q;

endmodule

// File: tb/tb_lcdi_index_decode.sv
// ---------------------------------------------------------------------------
// tb_lcdi_index_decode
// Directed self-checking bench for lcdi_index_decode. Inputs are driven and
// outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_lcdi_index_decode;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] index0, index1, index2, index3;
    logic [7:0] center_in;
    logic       busy, out_valid, out_ready, out_err, done;
    logic [1:0] out_slot;
    logic [7:0] recon0_out, recon2_out;
    logic [3:0] g0_out, g1_out;

    int tests_run    = 0;
    int tests_failed = 0;

    lcdi_index_decode dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .index0     (index0),
        .index1     (index1),
        .index2     (index2),
        .index3     (index3),
        .center_in  (center_in),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_slot   (out_slot),
        .recon0_out (recon0_out),
        .recon2_out (recon2_out),
        .g0_out     (g0_out),
        .g1_out     (g1_out),
        .out_err    (out_err),
        .done       (done)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Drive a one-cycle start; returns on the falling edge of the first LOAD cycle.
    task automatic pulse_start(input logic [6:0] a, input logic [6:0] b,
                               input logic [6:0] c, input logic [6:0] d,
                               input logic [7:0] cen);
        @(negedge clk);
        start = 1'b1; index0 = a; index1 = b; index2 = c; index3 = d; center_in = cen;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges until out_valid is seen, bounded.
    task automatic wait_valid(output int cyc, output bit tmo);
        cyc = 0;
        tmo = 1'b0;
        while (out_valid !== 1'b1) begin
            if (cyc >= 40) begin
                tmo = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        index0 = '0; index1 = '0; index2 = '0; index3 = '0; center_in = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy, out_valid, done, out_err, out_slot, g0_out, g1_out, recon0_out, recon2_out} !== 30'd0)
            begin tests_failed++; $display("[TB] FAIL reset_outputs: got busy=%b valid=%b done=%b err=%b slot=%0d g0=%0d g1=%0d r0=%0d r2=%0d, expected all 0",
                busy, out_valid, done, out_err, out_slot, g0_out, g1_out, recon0_out, recon2_out); end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            begin tests_failed++; $display("[TB] FAIL reset_idle: got busy=%b valid=%b, expected 0 0", busy, out_valid); end
    endtask

    task automatic test_decode();
        int idxT [3][4] = '{'{0, 40, 100, 13}, '{80, 0, 9, 127}, '{0, 80, 44, 17}};
        int cenT [3]    = '{100, 20, 230};
        int eg0  [3][4] = '{'{0, 4, 4, 4}, '{8, 0, 0, 4}, '{0, 8, 8, 8}};
        int eg1  [3][4] = '{'{0, 4, 4, 1}, '{8, 0, 1, 4}, '{0, 8, 4, 1}};
        int er0  [3][4] = '{'{156, 100, 100, 100}, '{0, 76, 76, 20}, '{255, 174, 174, 174}};
        int er2  [3][4] = '{'{156, 100, 100, 140}, '{0, 76, 60, 20}, '{255, 174, 230, 255}};
        int eerr [3][4] = '{'{0, 0, 1, 0}, '{0, 0, 0, 1}, '{0, 0, 0, 0}};
        int elat [3][4] = '{'{3, 7, 2, 4}, '{11, 3, 4, 2}, '{3, 11, 7, 4}};
        int cyc;
        bit tmo;
        out_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            pulse_start(7'(idxT[f][0]), 7'(idxT[f][1]), 7'(idxT[f][2]), 7'(idxT[f][3]), 8'(cenT[f]));
            for (int s = 0; s < 4; s++) begin
                wait_valid(cyc, tmo);
                tests_run++;
                if (tmo || cyc != elat[f][s])
                    begin tests_failed++; $display("[TB] FAIL latency f%0d s%0d: got %0d cycles (timeout=%0b), expected %0d", f, s, cyc, tmo, elat[f][s]); end
                tests_run++;
                if (out_slot !== 2'(s) || g0_out !== 4'(eg0[f][s]) || g1_out !== 4'(eg1[f][s]) || out_err !== 1'(eerr[f][s]))
                    begin tests_failed++; $display("[TB] FAIL classes f%0d s%0d: got slot=%0d g0=%0d g1=%0d err=%b, expected slot=%0d g0=%0d g1=%0d err=%0d",
                        f, s, out_slot, g0_out, g1_out, out_err, s, eg0[f][s], eg1[f][s], eerr[f][s]); end
                tests_run++;
                if (recon0_out !== 8'(er0[f][s]) || recon2_out !== 8'(er2[f][s]))
                    begin tests_failed++; $display("[TB] FAIL recon f%0d s%0d: got r0=%0d r2=%0d, expected r0=%0d r2=%0d",
                        f, s, recon0_out, recon2_out, er0[f][s], er2[f][s]); end
                @(negedge clk);
                if (s < 3) begin
                    tests_run++;
                    if (out_valid !== 1'b0 || busy !== 1'b1 || out_err !== 1'b0 || done !== 1'b0)
                        begin tests_failed++; $display("[TB] FAIL slot_gap f%0d s%0d: got valid=%b busy=%b err=%b done=%b, expected 0 1 0 0",
                            f, s, out_valid, busy, out_err, done); end
                end else begin
                    tests_run++;
                    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
                        begin tests_failed++; $display("[TB] FAIL done_pulse f%0d: got done=%b busy=%b valid=%b, expected 1 0 0", f, done, busy, out_valid); end
                    @(negedge clk);
                    tests_run++;
                    if (done !== 1'b0)
                        begin tests_failed++; $display("[TB] FAIL done_width f%0d: got done=%b, expected 0", f, done); end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int eg1 [4] = '{1, 2, 3, 4};
        int er2 [4] = '{90, 74, 60, 50};
        int cyc;
        int dcount = 0;
        bit tmo;
        bit stable = 1'b1;
        out_ready = 1'b0;
        pulse_start(7'd9, 7'd18, 7'd27, 7'd36, 8'd50);
        wait_valid(cyc, tmo);
        tests_run++;
        if (tmo)
            begin tests_failed++; $display("[TB] FAIL bp_first_valid: got timeout after %0d cycles, expected valid", cyc); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_slot !== 2'd0 || g0_out !== 4'd0 || g1_out !== 4'd1 ||
                recon0_out !== 8'd106 || recon2_out !== 8'd90 || busy !== 1'b1)
                stable = 1'b0;
            if (k == 1) begin
                start = 1'b1; index0 = 7'd0; index1 = 7'd0; index2 = 7'd0; index3 = 7'd0; center_in = 8'd0;
            end
            if (k == 2) start = 1'b0;
        end
        tests_run++;
        if (!stable)
            begin tests_failed++; $display("[TB] FAIL bp_hold: got valid=%b slot=%0d g1=%0d r0=%0d r2=%0d, expected 1 0 1 106 90",
                out_valid, out_slot, g1_out, recon0_out, recon2_out); end
        out_ready = 1'b1;
        @(negedge clk);
        for (int s = 1; s < 4; s++) begin
            wait_valid(cyc, tmo);
            tests_run++;
            if (tmo || out_slot !== 2'(s) || g1_out !== 4'(eg1[s]) || recon2_out !== 8'(er2[s]) || recon0_out !== 8'd106)
                begin tests_failed++; $display("[TB] FAIL bp_slot s%0d: got tmo=%b slot=%0d g1=%0d r0=%0d r2=%0d, expected slot=%0d g1=%0d r0=106 r2=%0d",
                    s, tmo, out_slot, g1_out, recon0_out, recon2_out, s, eg1[s], er2[s]); end
            @(negedge clk);
        end
        dcount += int'(done);
        repeat (5) begin
            @(negedge clk);
            dcount += int'(done);
        end
        tests_run++;
        if (dcount != 1)
            begin tests_failed++; $display("[TB] FAIL bp_done_count: got %0d pulses, expected 1", dcount); end
    endtask

    task automatic test_reset_midframe();
        int eg0 [4] = '{4, 4, 4, 8};
        int eg1 [4] = '{4, 1, 4, 8};
        int er0 [4] = '{77, 77, 77, 21};
        int er2 [4] = '{77, 117, 77, 21};
        int eerr[4] = '{0, 0, 1, 0};
        int cyc;
        bit tmo;
        bit quiet = 1'b1;
        out_ready = 1'b1;
        pulse_start(7'd0, 7'd0, 7'd80, 7'd0, 8'd100);
        for (int s = 0; s < 2; s++) begin
            wait_valid(cyc, tmo);
            tests_run++;
            if (tmo || out_slot !== 2'(s))
                begin tests_failed++; $display("[TB] FAIL rst_pre s%0d: got tmo=%b slot=%0d, expected slot=%0d", s, tmo, out_slot, s); end
            @(negedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests_run++;
        if ({busy, out_valid, done, out_err, out_slot, g0_out, g1_out, recon0_out, recon2_out} !== 30'd0)
            begin tests_failed++; $display("[TB] FAIL rst_mid_outputs: got busy=%b valid=%b done=%b err=%b slot=%0d g0=%0d g1=%0d r0=%0d r2=%0d, expected all 0",
                busy, out_valid, done, out_err, out_slot, g0_out, g1_out, recon0_out, recon2_out); end
        repeat (12) begin
            @(negedge clk);
            if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet)
            begin tests_failed++; $display("[TB] FAIL rst_mid_idle: got activity after reset (busy=%b valid=%b done=%b), expected idle", busy, out_valid, done); end
        pulse_start(7'd40, 7'd13, 7'd100, 7'd80, 8'd77);
        for (int s = 0; s < 4; s++) begin
            wait_valid(cyc, tmo);
            tests_run++;
            if (tmo || out_slot !== 2'(s) || g0_out !== 4'(eg0[s]) || g1_out !== 4'(eg1[s]) || out_err !== 1'(eerr[s]))
                begin tests_failed++; $display("[TB] FAIL rst_fresh_cls s%0d: got tmo=%b slot=%0d g0=%0d g1=%0d err=%b, expected g0=%0d g1=%0d err=%0d",
                    s, tmo, out_slot, g0_out, g1_out, out_err, eg0[s], eg1[s], eerr[s]); end
            tests_run++;
            if (recon0_out !== 8'(er0[s]) || recon2_out !== 8'(er2[s]))
                begin tests_failed++; $display("[TB] FAIL rst_fresh_recon s%0d: got r0=%0d r2=%0d, expected r0=%0d r2=%0d",
                    s, recon0_out, recon2_out, er0[s], er2[s]); end
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1)
            begin tests_failed++; $display("[TB] FAIL rst_fresh_done: got done=%b, expected 1", done); end
        @(negedge clk);
    endtask

    // Scenario sequence, then the summary.
    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
